// File: rtl/lane_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_register_pkg
// Description : Shared types for the lane-split CPU register family: bus op
//               codes, step direction and ripple state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_register_pkg;

    // Bus operation per lane (shared with the other CPU registers)
    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

    // Direction of the lane-serial step engine
    typedef enum logic {
        STEP_INC = 1'b0,
        STEP_DEC = 1'b1
    } step_dir_t;

    // Ripple engine state, kept as plain encoded constants
    typedef logic [0:0] lane_fsm_t;
    localparam lane_fsm_t LANE_IDLE   = 1'b0;
    localparam lane_fsm_t LANE_RIPPLE = 1'b1;

    // Width of the lane index; a single-lane register still needs one bit
    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_register_step.sv
`default_nettype none
// ============================================================================
// Module      : lane_step
// Description : One-lane add/subtract of a carry/borrow-in. Returns the new
//               lane value and the carry (inc) or borrow (dec) out.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_step
    import lane_register_pkg::*;
#(
    parameter int LANE_WIDTH = 4
) (
    input  logic [LANE_WIDTH-1:0] lane_in,
    input  step_dir_t             dir,
    input  logic                  carry_in,
    output logic [LANE_WIDTH-1:0] lane_out,
    output logic                  carry_out
);

    logic [LANE_WIDTH:0] w_ext;

    // Extended add/sub; the top bit is the carry or borrow out
    always_comb begin
        w_ext = '0;
        if (dir == STEP_INC) begin
            w_ext = {1'b0, lane_in} + {{LANE_WIDTH{1'b0}}, carry_in};
        end else begin
            w_ext = {1'b0, lane_in} - {{LANE_WIDTH{1'b0}}, carry_in};
        end
    end

    assign lane_out  = w_ext[LANE_WIDTH-1:0];
    assign carry_out = w_ext[LANE_WIDTH];

endmodule
`default_nettype wire

// File: rtl/lane_register.sv
`default_nettype none
// ============================================================================
// Module      : lane_register
// Description : Split register of LANES lanes x LANE_WIDTH bits. Each lane
//               loads from the main bus or the narrow B bus and can drive the
//               tri-state main bus. A lane-serial inc/dec engine ripples the
//               carry one lane per clock edge (state changes on negedge clk).
//               Build option LANE_REGISTER_SAT_EN: saturating instead of
//               wrapping step; step_flag then signals saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_register
    import lane_register_pkg::*;
#(
    parameter int                            LANE_WIDTH  = 4,
    parameter int                            LANES       = 2,
    parameter logic [LANE_WIDTH*LANES-1:0]   RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  reg_op_t                       op [LANES],
    input  logic [LANES-1:0]              b_load,
    input  logic [LANE_WIDTH*LANES-1:0]   bus_in,
    input  logic [LANE_WIDTH-1:0]         bus_b_in,
    input  logic                          step_req,
    input  step_dir_t                     step_dir,
    output logic                          step_busy,
    output logic                          step_flag,
    output logic [LANE_WIDTH*LANES-1:0]   bus_out,
    output logic [LANE_WIDTH*LANES-1:0]   always_bus_out
);

    localparam int c_width = LANE_WIDTH * LANES;
    localparam int c_idx_w = lane_idx_width(LANES);

    logic [c_width-1:0]                 r_state;
    lane_fsm_t                          r_fsm;
    logic [c_idx_w-1:0]                 r_idx;
    step_dir_t                          r_dir;
    logic                               r_flag;

    logic [LANES-1:0]                   w_load_lane;
    logic [LANES-1:0][LANE_WIDTH-1:0]   w_load_data;
    logic                               w_load_any;
    logic [LANE_WIDTH-1:0]              w_lane_sel;
    logic [LANE_WIDTH-1:0]              w_lane_new;
    logic                               w_carry;
    step_dir_t                          w_dir;
    logic                               w_sat;
    logic                               w_single_wr;
    logic [LANE_WIDTH-1:0]              w_bcast;

    // Per-lane load source: main bus READ has priority over the B bus
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_load
            assign w_load_lane[i] = (op[i] == REG_OP_READ) | b_load[i];
            assign w_load_data[i] = (op[i] == REG_OP_READ)
                                  ? bus_in[i*LANE_WIDTH +: LANE_WIDTH]
                                  : bus_b_in;
        end
    endgenerate

    assign w_load_any = |w_load_lane;

    // The engine works on lane 0 when idle and on lane idx while rippling;
    // direction comes live from the port at start, then from the held copy
    assign w_lane_sel = r_state[int'(r_idx)*LANE_WIDTH +: LANE_WIDTH];
    assign w_dir      = (r_fsm == LANE_IDLE) ? step_dir : r_dir;

    lane_step #(
        .LANE_WIDTH (LANE_WIDTH)
    ) u_lane_step (
        .lane_in   (w_lane_sel),
        .dir       (w_dir),
        .carry_in  (1'b1),
        .lane_out  (w_lane_new),
        .carry_out (w_carry)
    );

`ifdef LANE_REGISTER_SAT_EN
    assign w_sat = (step_dir == STEP_INC) ? (&r_state) : ~(|r_state);
`else
    assign w_sat = 1'b0;
`endif

    // Broadcast detection: exactly one WRITE lane and every other lane idle
    always_comb begin
        int n_write;
        int n_none;
        int src;
        n_write = 0;
        n_none  = 0;
        src     = 0;
        for (int i = 0; i < LANES; i++) begin
            if (op[i] == REG_OP_WRITE) begin
                n_write = n_write + 1;
                src     = i;
            end else if (op[i] == REG_OP_NONE) begin
                n_none = n_none + 1;
            end
        end
        w_single_wr = (n_write == 1) && (n_none == LANES - 1);
        w_bcast     = r_state[src*LANE_WIDTH +: LANE_WIDTH];
    end

    // Tri-state drive: own lane on WRITE, replicated single writer otherwise
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_bus
            assign bus_out[j*LANE_WIDTH +: LANE_WIDTH] =
                (op[j] == REG_OP_WRITE) ? r_state[j*LANE_WIDTH +: LANE_WIDTH] :
                w_single_wr             ? w_bcast :
                                          {LANE_WIDTH{1'bz}};
        end
    endgenerate

    // Register state, ripple engine and wrap/saturate pulse
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_VALUE;
            r_fsm   <= LANE_IDLE;
            r_idx   <= '0;
            r_dir   <= STEP_INC;
            r_flag  <= 1'b0;
        end else begin
            r_flag <= 1'b0;
            if (w_load_any) begin
                // Loads win over any step and cancel a ripple in flight
                for (int i = 0; i < LANES; i++) begin
                    if (w_load_lane[i]) begin
                        r_state[i*LANE_WIDTH +: LANE_WIDTH] <= w_load_data[i];
                    end
                end
                r_fsm <= LANE_IDLE;
                r_idx <= '0;
            end else begin
                case (r_fsm)
                    LANE_IDLE: begin
                        if (step_req) begin
                            if (w_sat) begin
                                r_flag <= 1'b1;
                            end else begin
                                r_state[LANE_WIDTH-1:0] <= w_lane_new;
                                r_dir                   <= step_dir;
                                if (w_carry) begin
                                    if (LANES > 1) begin
                                        r_fsm <= LANE_RIPPLE;
                                        r_idx <= c_idx_w'(1);
                                    end else begin
                                        r_flag <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    LANE_RIPPLE: begin
                        r_state[int'(r_idx)*LANE_WIDTH +: LANE_WIDTH] <= w_lane_new;
                        if (w_carry && (int'(r_idx) < LANES - 1)) begin
                            r_idx <= r_idx + c_idx_w'(1);
                        end else begin
                            r_fsm <= LANE_IDLE;
                            r_idx <= '0;
                            if (w_carry) begin
                                r_flag <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_fsm <= LANE_IDLE;
                        r_idx <= '0;
                    end
                endcase
            end
        end
    end

    assign step_busy      = (r_fsm == LANE_RIPPLE);
    assign step_flag      = r_flag;
    assign always_bus_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lane_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_register
// Description : Scoreboard bench for lane_register: a 2-lane and a 4-lane
//               instance driven with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_register;
    import lane_register_pkg::*;

    typedef struct {
        int          dut;
        string       name;
        logic [15:0] st;
        logic        busy;
        logic        flag;
        logic [15:0] bus;
        logic [15:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    reg_op_t     op_a [2];
    logic [1:0]  bl_a;
    logic [7:0]  bin_a;
    logic [3:0]  bb_a;
    logic        req_a;
    step_dir_t   dir_a;
    logic        busy_a, flag_a;
    wire  [7:0]  bus_a;
    logic [7:0]  abo_a;

    reg_op_t     op_b [4];
    logic [3:0]  bl_b;
    logic [15:0] bin_b;
    logic [3:0]  bb_b;
    logic        req_b;
    step_dir_t   dir_b;
    logic        busy_b, flag_b;
    wire  [15:0] bus_b;
    logic [15:0] abo_b;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    lane_register #(.LANE_WIDTH(4), .LANES(2), .RESET_VALUE(8'h00)) u_dut_a (
        .clk(clk), .rst(rst), .op(op_a), .b_load(bl_a), .bus_in(bin_a),
        .bus_b_in(bb_a), .step_req(req_a), .step_dir(dir_a),
        .step_busy(busy_a), .step_flag(flag_a), .bus_out(bus_a),
        .always_bus_out(abo_a)
    );

    lane_register #(.LANE_WIDTH(4), .LANES(4), .RESET_VALUE(16'h1234)) u_dut_b (
        .clk(clk), .rst(rst), .op(op_b), .b_load(bl_b), .bus_in(bin_b),
        .bus_b_in(bb_b), .step_req(req_b), .step_dir(dir_b),
        .step_busy(busy_b), .step_flag(flag_b), .bus_out(bus_b),
        .always_bus_out(abo_b)
    );

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: state settles on negedge, sampled on the following posedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    chk(e.name, "state", {8'h00, abo_a}, e.st);
                    chk(e.name, "busy",  {15'h0, busy_a}, {15'h0, e.busy});
                    chk(e.name, "flag",  {15'h0, flag_a}, {15'h0, e.flag});
                    if (e.mask != 16'h0)
                        chk(e.name, "bus", {8'h00, bus_a} & e.mask, e.bus & e.mask);
                end else begin
                    chk(e.name, "state", abo_b, e.st);
                    chk(e.name, "busy",  {15'h0, busy_b}, {15'h0, e.busy});
                    chk(e.name, "flag",  {15'h0, flag_b}, {15'h0, e.flag});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        op_a[0] = REG_OP_NONE; op_a[1] = REG_OP_NONE;
        bl_a = '0; bin_a = '0; bb_a = '0; req_a = 1'b0; dir_a = STEP_INC;
        for (int i = 0; i < 4; i++) op_b[i] = REG_OP_NONE;
        bl_b = '0; bin_b = '0; bb_b = '0; req_b = 1'b0; dir_b = STEP_INC;
    endtask

    task automatic exp_a(input string nm, input logic [7:0] st, input logic busy, input logic flag);
        exp_t e;
        e.dut = 0; e.name = nm; e.st = {8'h00, st}; e.busy = busy; e.flag = flag;
        e.bus = '0; e.mask = '0;
        q.push_back(e);
    endtask

    task automatic exp_a_bus(input string nm, input logic [7:0] st, input logic [7:0] bus, input logic [7:0] mask);
        exp_t e;
        e.dut = 0; e.name = nm; e.st = {8'h00, st}; e.busy = 1'b0; e.flag = 1'b0;
        e.bus = {8'h00, bus}; e.mask = {8'h00, mask};
        q.push_back(e);
    endtask

    task automatic exp_b(input string nm, input logic [15:0] st, input logic busy, input logic flag);
        exp_t e;
        e.dut = 1; e.name = nm; e.st = st; e.busy = busy; e.flag = flag;
        e.bus = '0; e.mask = '0;
        q.push_back(e);
    endtask

    task automatic load_a(input string nm, input logic [7:0] v);
        tick(); idle_all();
        op_a[0] = REG_OP_READ; op_a[1] = REG_OP_READ; bin_a = v;
        exp_a(nm, v, 1'b0, 1'b0);
    endtask

    task automatic step_a(input step_dir_t d);
        tick(); idle_all();
        req_a = 1'b1; dir_a = d;
    endtask

    // Stimulus
    initial begin
        idle_all();
        rst = 1'b1;
        tick();
        exp_a("reset_a", 8'h00, 1'b0, 1'b0);
        exp_b("reset_b", 16'h1234, 1'b0, 1'b0);
        tick(); rst = 1'b0;

        // Ripple increment over the lane boundary
        load_a("ld_0f", 8'h0F);
        step_a(STEP_INC);                  exp_a("rip_e1", 8'h00, 1'b1, 1'b0);
        tick(); idle_all();                exp_a("rip_e2", 8'h10, 1'b0, 1'b0);

        // Single-edge increment
        load_a("ld_3a", 8'h3A);
        step_a(STEP_INC);                  exp_a("inc_3a", 8'h3B, 1'b0, 1'b0);
        tick(); idle_all();                exp_a("inc_3a_idle", 8'h3B, 1'b0, 1'b0);

        // Increment at all-ones
        load_a("ld_ff", 8'hFF);
`ifdef LANE_REGISTER_SAT_EN
        step_a(STEP_INC);                  exp_a("sat_inc_e1", 8'hFF, 1'b0, 1'b1);
        tick(); idle_all();                exp_a("sat_inc_e2", 8'hFF, 1'b0, 1'b0);
        tick();                            exp_a("sat_inc_e3", 8'hFF, 1'b0, 1'b0);
`else
        step_a(STEP_INC);                  exp_a("wrap_inc_e1", 8'hF0, 1'b1, 1'b0);
        tick(); idle_all();                exp_a("wrap_inc_e2", 8'h00, 1'b0, 1'b1);
        tick();                            exp_a("wrap_inc_e3", 8'h00, 1'b0, 1'b0);
`endif

        // Decrement at zero
        load_a("ld_00", 8'h00);
`ifdef LANE_REGISTER_SAT_EN
        step_a(STEP_DEC);                  exp_a("sat_dec_e1", 8'h00, 1'b0, 1'b1);
        tick(); idle_all();                exp_a("sat_dec_e2", 8'h00, 1'b0, 1'b0);
        tick();                            exp_a("sat_dec_e3", 8'h00, 1'b0, 1'b0);
`else
        step_a(STEP_DEC);                  exp_a("wrap_dec_e1", 8'h0F, 1'b1, 1'b0);
        tick(); idle_all();                exp_a("wrap_dec_e2", 8'hFF, 1'b0, 1'b1);
        tick();                            exp_a("wrap_dec_e3", 8'hFF, 1'b0, 1'b0);
`endif

        // Load priority: READ beats B bus on lane 1, B bus loads lane 0
        tick(); idle_all();
        op_a[1] = REG_OP_READ; bin_a = 8'hA5; bl_a = 2'b11; bb_a = 4'h3;
        exp_a("ld_prio", 8'hA3, 1'b0, 1'b0);

        // B-bus load during ripple aborts it
        load_a("ld_0f_b", 8'h0F);
        step_a(STEP_INC);                  exp_a("abort_e1", 8'h00, 1'b1, 1'b0);
        tick(); idle_all(); bl_a = 2'b01; bb_a = 4'h7;
        exp_a("abort_e2", 8'h07, 1'b0, 1'b0);
        tick(); idle_all();                exp_a("abort_e3", 8'h07, 1'b0, 1'b0);

        // Load and step on the same idle edge: step dropped
        tick(); idle_all();
        op_a[1] = REG_OP_READ; bin_a = 8'h90; req_a = 1'b1;
        exp_a("ld_step", 8'h97, 1'b0, 1'b0);
        tick(); idle_all();                exp_a("ld_step_idle", 8'h97, 1'b0, 1'b0);

        // Held direction, and a request during busy ignored
        load_a("ld_0f_c", 8'h0F);
        step_a(STEP_INC);                  exp_a("hold_e1", 8'h00, 1'b1, 1'b0);
        tick(); idle_all(); req_a = 1'b1; dir_a = STEP_DEC;
        exp_a("hold_e2", 8'h10, 1'b0, 1'b0);
        tick(); idle_all();                exp_a("hold_e3", 8'h10, 1'b0, 1'b0);

        // Bus drive patterns
        load_a("ld_5c", 8'h5C);
        tick(); idle_all(); op_a[0] = REG_OP_WRITE;
        exp_a_bus("bus_lo_bcast", 8'h5C, 8'hCC, 8'hFF);
        tick(); idle_all(); op_a[1] = REG_OP_WRITE;
        exp_a_bus("bus_hi_bcast", 8'h5C, 8'h55, 8'hFF);
        tick(); idle_all(); op_a[0] = REG_OP_WRITE; op_a[1] = REG_OP_WRITE;
        exp_a_bus("bus_both", 8'h5C, 8'h5C, 8'hFF);
        tick(); idle_all(); op_a[0] = REG_OP_WRITE; op_a[1] = REG_OP_READ; bin_a = 8'h50;
        exp_a_bus("bus_rd_wr", 8'h5C, 8'h0C, 8'h0F);

        // Asynchronous reset in the middle of a ripple
        load_a("ld_0f_d", 8'h0F);
        step_a(STEP_INC);                  exp_a("rstmid_e1", 8'h00, 1'b1, 1'b0);
        tick(); idle_all(); rst = 1'b1;
        exp_a("rstmid_rst", 8'h00, 1'b0, 1'b0);
        exp_b("rstmid_rst_b", 16'h1234, 1'b0, 1'b0);
        tick(); rst = 1'b0;
        exp_a("rstmid_after", 8'h00, 1'b0, 1'b0);

        // Four-lane ripple, request during busy ignored
        tick(); idle_all();
        for (int i = 0; i < 4; i++) op_b[i] = REG_OP_READ;
        bin_b = 16'h0FFF;
        exp_b("b_ld", 16'h0FFF, 1'b0, 1'b0);
        tick(); idle_all(); req_b = 1'b1;  exp_b("b_e1", 16'h0FF0, 1'b1, 1'b0);
        tick(); idle_all(); req_b = 1'b1;  exp_b("b_e2", 16'h0F00, 1'b1, 1'b0);
        tick(); idle_all();                exp_b("b_e3", 16'h0000, 1'b1, 1'b0);
        tick(); idle_all();                exp_b("b_e4", 16'h1000, 1'b0, 1'b0);
        tick(); idle_all();                exp_b("b_e5", 16'h1000, 1'b0, 1'b0);

        tick(); tick();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
